instr_fetch_unit: RTL and testbench

- Drives the program counter rather than receiving from it.
- Reads the current PC, issues a read to instruction memory over a req/ack handshake, and captures the returned word.
- Presents the word to the decoder over valid/ready, then pulses pc_inc to advance the PC.
- Converts decoder branch requests into pc_load/pc_load_val and discards any in-flight fetch.

---
 rtl/instr_fetch_unit_if.sv | 34 +++
 rtl/instr_fetch_unit.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle for instr_fetch_unit: PC control, instruction memory and decoder handshakes.
// master = fetch unit side, slave = PC / memory / decoder side.
interface instr_fetch_unit_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 16
) ();
    logic [ADDR_WIDTH-1:0] pc;
    logic                  pc_inc;
    logic                  pc_load;
    logic [ADDR_WIDTH-1:0] pc_load_val;
    logic                  branch_req;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] instr_pc;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  fault;

    modport master (
        input  pc, branch_req, branch_target, mem_ack, mem_rdata, instr_ready,
        output pc_inc, pc_load, pc_load_val, mem_req, mem_addr, instr, instr_pc, instr_valid,
               fault
    );

    modport slave (
        output pc, branch_req, branch_target, mem_ack, mem_rdata, instr_ready,
        input  pc_inc, pc_load, pc_load_val, mem_req, mem_addr, instr, instr_pc, instr_valid,
               fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: drives the PC, reads memory over req/ack, hands words to the decoder.
// Optional memory-wait timeout with sticky fault is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input logic               clk_i,
    input logic               reset_i,
    instr_fetch_unit_if.master bus_io
);
    typedef enum logic [2:0] {StIdle, StReq, StHold, StFlush, StSettle, StFault} state_e;

    state_e                state_q, state_d;
    logic                  pc_inc_q, pc_inc_d;
    logic                  pc_load_q, pc_load_d;
    logic [ADDR_WIDTH-1:0] pc_load_val_q, pc_load_val_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                  mem_req;
    logic                  waiting;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            fault_q, fault_d;
    logic            timeout;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    assign mem_req = (state_q == StReq) || (state_q == StFlush);
    assign waiting = mem_req && !bus_io.mem_ack;

`ifdef FETCH_TIMEOUT_EN
    assign timeout = waiting && (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d       = state_q;
        pc_inc_d      = 1'b0;
        pc_load_d     = 1'b0;
        pc_load_val_d = pc_load_val_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        req_addr_d    = req_addr_q;
`ifdef FETCH_TIMEOUT_EN
        tmo_cnt_d     = waiting ? tmo_cnt_q + CntW'(1) : '0;
        fault_d       = fault_q;
`endif
        if (state_q == StReq) begin
            req_addr_d = bus_io.pc;
        end

        // Branch wins over everything except a latched fault; an outstanding read must drain.
        if (bus_io.branch_req && state_q != StFault) begin
            pc_load_d     = 1'b1;
            pc_load_val_d = bus_io.branch_target;
            instr_valid_d = 1'b0;
            state_d       = waiting ? StFlush : StSettle;
`ifdef FETCH_TIMEOUT_EN
        end else if (timeout) begin
            fault_d = 1'b1;
            state_d = StFault;
`endif
        end else begin
            unique case (state_q)
                StIdle:   state_d = StReq;
                StReq: begin
                    if (bus_io.mem_ack) begin
                        instr_d       = bus_io.mem_rdata;
                        instr_pc_d    = bus_io.pc;
                        instr_valid_d = 1'b1;
                        pc_inc_d      = 1'b1;
                        state_d       = StHold;
                    end
                end
                StHold: begin
                    if (bus_io.instr_ready) begin
                        instr_valid_d = 1'b0;
                        state_d       = StReq;
                    end
                end
                StFlush: begin
                    if (bus_io.mem_ack) begin
                        state_d = StReq;
                    end
                end
                StSettle: state_d = StReq;
                StFault:  state_d = StFault;
                default:  state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StIdle;
            pc_inc_q      <= 1'b0;
            pc_load_q     <= 1'b0;
            pc_load_val_q <= '0;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            req_addr_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q     <= '0;
            fault_q       <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_inc_q      <= pc_inc_d;
            pc_load_q     <= pc_load_d;
            pc_load_val_q <= pc_load_val_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            req_addr_q    <= req_addr_d;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt_q     <= tmo_cnt_d;
            fault_q       <= fault_d;
`endif
        end
    end

    assign bus_io.pc_inc      = pc_inc_q;
    assign bus_io.pc_load     = pc_load_q;
    assign bus_io.pc_load_val = pc_load_val_q;
    assign bus_io.mem_req     = mem_req;
    // FLUSH keeps the stale address: the PC has already moved to the branch target.
    assign bus_io.mem_addr    = (state_q == StFlush) ? req_addr_q : bus_io.pc;
    assign bus_io.instr       = instr_q;
    assign bus_io.instr_pc    = instr_pc_q;
    assign bus_io.instr_valid = instr_valid_q;
`ifdef FETCH_TIMEOUT_EN
    assign bus_io.fault       = fault_q;
`else
    assign bus_io.fault       = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a PC register model and a wait-state memory model.
// Define FETCH_TIMEOUT_EN to also exercise the timeout/fault path (TIMEOUT_CYCLES = 8).
module tb_instr_fetch_unit;
`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TmoCycles = 8;
`else
    localparam int unsigned TmoCycles = 255;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic ack_en;
    int   wait_cycles;
    int   wait_cnt;

    instr_fetch_unit_if #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

    instr_fetch_unit #(
        .DATA_WIDTH     (16),
        .ADDR_WIDTH     (16),
        .TIMEOUT_CYCLES (TmoCycles)
    ) dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus_io  (bus.master)
    );

    always #5 clk = ~clk;

    // PC register owned by the environment
    always_ff @(posedge clk) begin
        if (reset) bus.pc <= '0;
        else if (bus.pc_load) bus.pc <= bus.pc_load_val;
        else if (bus.pc_inc) bus.pc <= bus.pc + 16'd1;
    end

    // Memory: acks once the request has waited wait_cycles cycles; data = 0x1000 + addr
    always_comb begin
        bus.mem_ack   = ack_en && bus.mem_req && (wait_cnt >= wait_cycles);
        bus.mem_rdata = 16'h1000 + bus.mem_addr;
    end

    always_ff @(posedge clk) begin
        if (reset || !bus.mem_req || bus.mem_ack) wait_cnt <= 0;
        else wait_cnt <= wait_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; bus.instr_ready = 1'b0; bus.branch_req = 1'b0; bus.branch_target = '0;
        ack_en = 1'b1; wait_cycles = 0;
        step(); step();
        checks++;
        if ({bus.pc_inc, bus.pc_load, bus.pc_load_val, bus.mem_req, bus.instr, bus.instr_pc,
             bus.instr_valid, bus.fault} !== 53'd0) begin
            errors++;
            $display("FAIL reset_outputs: got inc=%0b load=%0b val=%h req=%0b instr=%h ipc=%h v=%0b f=%0b want all 0",
                     bus.pc_inc, bus.pc_load, bus.pc_load_val, bus.mem_req, bus.instr,
                     bus.instr_pc, bus.instr_valid, bus.fault);
        end
        reset = 1'b0;
        bus.instr_ready = 1'b1;
    endtask

    task automatic test_stream();
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({bus.mem_req, bus.mem_addr, bus.instr_valid, bus.pc_inc} !== {1'b1, 16'(k), 2'b00}) begin
                errors++;
                $display("FAIL stream_req[%0d]: got req=%0b addr=%h v=%0b inc=%0b want 1/%h/0/0",
                         k, bus.mem_req, bus.mem_addr, bus.instr_valid, bus.pc_inc, 16'(k));
            end
            step();
            checks++;
            if ({bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_inc} !==
                {1'b1, 16'(16'h1000 + k), 16'(k), 1'b1}) begin
                errors++;
                $display("FAIL stream_word[%0d]: got v=%0b instr=%h ipc=%h inc=%0b want 1/%h/%h/1",
                         k, bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_inc,
                         16'(16'h1000 + k), 16'(k));
            end
        end
    endtask

    task automatic test_stall();
        step();
        checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 16'h0003}) begin
            errors++;
            $display("FAIL stall_req: got req=%0b addr=%h want 1/0003", bus.mem_req, bus.mem_addr);
        end
        bus.instr_ready = 1'b0;
        step();
        checks++;
        if ({bus.instr_valid, bus.instr, bus.pc_inc} !== {1'b1, 16'h1003, 1'b1}) begin
            errors++;
            $display("FAIL stall_first: got v=%0b instr=%h inc=%0b want 1/1003/1",
                     bus.instr_valid, bus.instr, bus.pc_inc);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_req, bus.pc_inc} !==
                {1'b1, 16'h1003, 16'h0003, 2'b00}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%0b instr=%h ipc=%h req=%0b inc=%0b want 1/1003/0003/0/0",
                         i, bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_req, bus.pc_inc);
            end
        end
        checks++;
        if (bus.pc !== 16'h0004) begin
            errors++;
            $display("FAIL stall_pc: got %h want 0004", bus.pc);
        end
        bus.instr_ready = 1'b1;
    endtask

    task automatic test_wait_states();
        wait_cycles = 3;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if ({bus.mem_req, bus.mem_addr, bus.pc_inc, bus.instr_valid} !== {1'b1, 16'h0004, 2'b00}) begin
                errors++;
                $display("FAIL wait_req[%0d]: got req=%0b addr=%h inc=%0b v=%0b want 1/0004/0/0",
                         i, bus.mem_req, bus.mem_addr, bus.pc_inc, bus.instr_valid);
            end
        end
        step();
        checks++;
        if ({bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_inc} !== {1'b1, 16'h1004, 16'h0004, 1'b1}) begin
            errors++;
            $display("FAIL wait_word: got v=%0b instr=%h ipc=%h inc=%0b want 1/1004/0004/1",
                     bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_inc);
        end
    endtask

    task automatic test_branch_flush();
        int  n;
        logic found;
        step();
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_ack} !== {1'b1, 16'h0005, 1'b0}) begin
            errors++;
            $display("FAIL br_pending: got req=%0b addr=%h ack=%0b want 1/0005/0",
                     bus.mem_req, bus.mem_addr, bus.mem_ack);
        end
        bus.branch_req = 1'b1; bus.branch_target = 16'h0ABC;
        step();
        bus.branch_req = 1'b0;
        checks++;
        if ({bus.pc_load, bus.pc_load_val, bus.pc_inc, bus.instr_valid, bus.mem_req, bus.mem_addr} !==
            {1'b1, 16'h0ABC, 2'b00, 1'b1, 16'h0005}) begin
            errors++;
            $display("FAIL br_load: got load=%0b val=%h inc=%0b v=%0b req=%0b addr=%h want 1/0abc/0/0/1/0005",
                     bus.pc_load, bus.pc_load_val, bus.pc_inc, bus.instr_valid, bus.mem_req, bus.mem_addr);
        end
        found = 1'b0;
        n = 0;
        while (!found && n < 10) begin
            step();
            n++;
            checks++;
            if ({bus.pc_load, bus.instr_valid, bus.pc_inc} !== 3'b000) begin
                errors++;
                $display("FAIL br_flush[%0d]: got load=%0b v=%0b inc=%0b want 0/0/0",
                         n, bus.pc_load, bus.instr_valid, bus.pc_inc);
            end
            if (bus.mem_req && bus.mem_addr == 16'h0ABC) found = 1'b1;
        end
        checks++;
        if (!found || n != 3) begin
            errors++;
            $display("FAIL br_refetch: got found=%0b after %0d cycles want 1 after 3", found, n);
        end
        wait_cycles = 0;
        step();
        checks++;
        if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 16'h1ABC, 16'h0ABC}) begin
            errors++;
            $display("FAIL br_word: got v=%0b instr=%h ipc=%h want 1/1abc/0abc",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
    endtask

    task automatic test_reset_in_hold();
        bus.instr_ready = 1'b0;
        reset = 1'b1;
        step();
        checks++;
        if ({bus.pc_inc, bus.pc_load, bus.pc_load_val, bus.mem_req, bus.instr, bus.instr_pc,
             bus.instr_valid, bus.fault, bus.pc} !== 69'd0) begin
            errors++;
            $display("FAIL rst_hold: got inc=%0b load=%0b req=%0b instr=%h v=%0b pc=%h want all 0",
                     bus.pc_inc, bus.pc_load, bus.mem_req, bus.instr, bus.instr_valid, bus.pc);
        end
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        step();
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.instr_valid} !== {1'b1, 16'h0000, 1'b0}) begin
            errors++;
            $display("FAIL rst_restart_req: got req=%0b addr=%h v=%0b want 1/0000/0",
                     bus.mem_req, bus.mem_addr, bus.instr_valid);
        end
        step();
        checks++;
        if ({bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_inc} !== {1'b1, 16'h1000, 16'h0000, 1'b1}) begin
            errors++;
            $display("FAIL rst_restart_word: got v=%0b instr=%h ipc=%h inc=%0b want 1/1000/0000/1",
                     bus.instr_valid, bus.instr, bus.instr_pc, bus.pc_inc);
        end
    endtask

    task automatic test_branch_in_hold();
        // ready=1 alongside the branch: the word must not be accepted
        bus.branch_req = 1'b1; bus.branch_target = 16'h0020;
        step();
        checks++;
        if ({bus.instr_valid, bus.pc_load, bus.pc_load_val, bus.pc_inc, bus.mem_req} !==
            {2'b01, 16'h0020, 2'b00}) begin
            errors++;
            $display("FAIL hold_branch: got v=%0b load=%0b val=%h inc=%0b req=%0b want 0/1/0020/0/0",
                     bus.instr_valid, bus.pc_load, bus.pc_load_val, bus.pc_inc, bus.mem_req);
        end
        bus.branch_target = 16'h0030;
        step();
        bus.branch_req = 1'b0;
        checks++;
        if ({bus.pc_load, bus.pc_load_val, bus.mem_req} !== {1'b1, 16'h0030, 1'b0}) begin
            errors++;
            $display("FAIL rebranch: got load=%0b val=%h req=%0b want 1/0030/0",
                     bus.pc_load, bus.pc_load_val, bus.mem_req);
        end
        step();
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.pc_load} !== {1'b1, 16'h0030, 1'b0}) begin
            errors++;
            $display("FAIL rebranch_req: got req=%0b addr=%h load=%0b want 1/0030/0",
                     bus.mem_req, bus.mem_addr, bus.pc_load);
        end
        step();
        checks++;
        if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 16'h1030, 16'h0030}) begin
            errors++;
            $display("FAIL rebranch_word: got v=%0b instr=%h ipc=%h want 1/1030/0030",
                     bus.instr_valid, bus.instr, bus.instr_pc);
        end
    endtask

`ifdef FETCH_TIMEOUT_EN
    task automatic test_timeout();
        ack_en = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            step();
            checks++;
            if ({bus.fault, bus.mem_req} !== 2'b01) begin
                errors++;
                $display("FAIL tmo_wait[%0d]: got fault=%0b req=%0b want 0/1", i, bus.fault, bus.mem_req);
            end
        end
        step();
        checks++;
        if ({bus.fault, bus.mem_req} !== 2'b10) begin
            errors++;
            $display("FAIL tmo_fault: got fault=%0b req=%0b want 1/0", bus.fault, bus.mem_req);
        end
        ack_en = 1'b1; bus.branch_req = 1'b1; bus.branch_target = 16'h0040;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({bus.fault, bus.mem_req, bus.pc_load, bus.pc_inc} !== 4'b1000) begin
                errors++;
                $display("FAIL tmo_sticky[%0d]: got fault=%0b req=%0b load=%0b inc=%0b want 1/0/0/0",
                         i, bus.fault, bus.mem_req, bus.pc_load, bus.pc_inc);
            end
        end
        bus.branch_req = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (bus.fault !== 1'b0) begin
            errors++;
            $display("FAIL tmo_reset: got fault=%0b want 0", bus.fault);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_wait_states();
        test_branch_flush();
        test_reset_in_hold();
        test_branch_in_hold();
`ifdef FETCH_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
